dsp_equation_engine: RTL and testbench

DSP_EQUATION_ENGINE -- requirements
Module: dsp_equation_engine

---
 rtl/dsp_engine_pkg.sv | 59 +++++
 rtl/dsp_equation_engine_if.sv | 35 +++
 rtl/dsp_engine_alu.sv | 56 +++++
 rtl/dsp_equation_engine.sv | 135 +++++++++++++
 tb/tb_dsp_equation_engine.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/dsp_engine_pkg.sv
// Shared types and helpers for the DSP equation engine.
// Mode/state encodings, accumulator sizing and range/saturation helpers.
package dsp_engine_pkg;

    typedef enum logic [1:0] {
        MODE_SUM  = 2'd0,
        MODE_MIN  = 2'd1,
        MODE_MAX  = 2'd2,
        MODE_MEAN = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_ACC   = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    localparam int CNT_W = 16;

    function automatic int acc_w(input int dw, input int gw);
        return dw + gw;
    endfunction

    function automatic logic is_pow2(input logic [CNT_W-1:0] c);
        return (c != '0) && ((c & (c - 16'd1)) == '0);
    endfunction

    function automatic logic [3:0] log2_cnt(input logic [CNT_W-1:0] c);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < CNT_W; i++)
            if (c[i]) r = 4'(i);
        return r;
    endfunction

    // Values are carried at 64 bits so one helper serves any DW/ACC_W <= 64.
    function automatic logic in_range(input logic signed [63:0] v,
                                      input int dw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return (v <= hi) && (v >= lo);
    endfunction

    function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                    input int dw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/dsp_equation_engine_if.sv
// Control and file-bus bundle of the DSP equation engine.
// master = engine side, slave = host/file-store side.
interface dsp_equation_engine_if #(
    parameter int DW = 32
);
    logic          start;
    logic [1:0]    mode;
    logic [15:0]   count;
    logic [7:0]    src_file;
    logic [7:0]    dst_file;
    logic [7:0]    file_num;
    logic          file_read;
    logic          file_read_valid;
    logic [DW-1:0] file_read_data;
    logic          file_write;
    logic          file_write_ready;
    logic [DW-1:0] file_write_data;
    logic          busy;
    logic          done;
    logic          error;

    modport master (
        input  start, mode, count, src_file, dst_file,
        input  file_read_valid, file_read_data, file_write_ready,
        output file_num, file_read, file_write, file_write_data,
        output busy, done, error
    );

    modport slave (
        output start, mode, count, src_file, dst_file,
        output file_read_valid, file_read_data, file_write_ready,
        input  file_num, file_read, file_write, file_write_data,
        input  busy, done, error
    );
endinterface

// File: rtl/dsp_engine_alu.sv
// One channel: accumulate / min / max, mean shift, range check.
// DSP_ENGINE_SAT_EN: clamp out-of-range results instead of wrapping.
module dsp_engine_alu
    import dsp_engine_pkg::*;
#(
    parameter int DW = 32,
    parameter int GW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 first,
    input  mode_e                mode,
    input  logic [3:0]           shamt,
    input  logic signed [DW-1:0] sample,
    output logic [DW-1:0]        result,
    output logic                 ovf
);
    localparam int ACC_W = acc_w(DW, GW);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] ext;
    logic signed [ACC_W-1:0] scaled;
    logic signed [63:0]      wide;

    assign ext = {{GW{sample[DW-1]}}, sample};

    // Channel accumulator; first sample of a job loads directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (en) begin
            if (first) begin
                acc <= ext;
            end else begin
                unique case (mode)
                    MODE_SUM, MODE_MEAN: acc <= acc + ext;
                    MODE_MIN: if (ext < acc) acc <= ext;
                    MODE_MAX: if (ext > acc) acc <= ext;
                endcase
            end
        end
    end

    // Scale for mean, then range-check and narrow to DW.
    always_comb begin
        scaled = (mode == MODE_MEAN) ? (acc >>> shamt) : acc;
        wide   = {{(64-ACC_W){scaled[ACC_W-1]}}, scaled};
        ovf    = !in_range(wide, DW);
`ifdef DSP_ENGINE_SAT_EN
        result = DW'(saturate(wide, DW));
`else
        result = DW'(scaled);
`endif
    end
endmodule

// File: rtl/dsp_equation_engine.sv
// Multi-channel SUM/MIN/MAX/MEAN engine over a file read/write bus.
// DSP_ENGINE_SAT_EN selects saturating results (default: wrap).
module dsp_equation_engine
    import dsp_engine_pkg::*;
#(
    parameter int DW     = 32,
    parameter int NUM_CH = 4,
    parameter int GW     = 16
) (
    input logic                  wb_clk,
    input logic                  wb_rst,
    dsp_equation_engine_if.master bus
);
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TW = CNT_W + 4;
    localparam logic [CW-1:0] LAST_CH = CW'(NUM_CH - 1);

    state_e               state;
    state_e               state_nxt;
    mode_e                mode_q;
    logic [3:0]           shamt_q;
    logic [7:0]           src_q;
    logic [7:0]           dst_q;
    logic [TW-1:0]        total_q;
    logic [TW-1:0]        word_cnt;
    logic [CW-1:0]        ch_idx;
    logic signed [DW-1:0] sample_q;
    logic                 err_q;
    logic                 bad_cfg;
    logic                 last_word;
    logic                 first;
    logic [DW-1:0]        res [NUM_CH];
    logic [NUM_CH-1:0]    ovf;

    assign bad_cfg = (bus.count == '0) ||
                     (mode_e'(bus.mode) == MODE_MEAN && !is_pow2(bus.count));
    assign last_word = (word_cnt == total_q - TW'(1));
    assign first = (word_cnt < TW'(NUM_CH));

    // State register.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (bus.start) state_nxt = bad_cfg ? S_DONE : S_READ;
            S_READ:  if (bus.file_read_valid) state_nxt = S_ACC;
            S_ACC:   state_nxt = last_word ? S_WRITE : S_READ;
            S_WRITE: if (bus.file_write_ready && ch_idx == LAST_CH)
                         state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Job configuration, counters, captured sample and sticky error.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            mode_q   <= MODE_SUM;
            shamt_q  <= '0;
            src_q    <= '0;
            dst_q    <= '0;
            total_q  <= '0;
            word_cnt <= '0;
            ch_idx   <= '0;
            sample_q <= '0;
            err_q    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: if (bus.start) begin
                    mode_q   <= mode_e'(bus.mode);
                    shamt_q  <= log2_cnt(bus.count);
                    src_q    <= bus.src_file;
                    dst_q    <= bus.dst_file;
                    total_q  <= TW'(bus.count) * TW'(NUM_CH);
                    word_cnt <= '0;
                    ch_idx   <= '0;
                    err_q    <= bad_cfg;
                end
                S_READ: if (bus.file_read_valid) sample_q <= bus.file_read_data;
                S_ACC: begin
                    word_cnt <= word_cnt + TW'(1);
                    ch_idx   <= (last_word || ch_idx == LAST_CH) ?
                                '0 : ch_idx + CW'(1);
                end
                S_WRITE: if (bus.file_write_ready) begin
                    ch_idx <= (ch_idx == LAST_CH) ? '0 : ch_idx + CW'(1);
                    if (ovf[ch_idx]) err_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        dsp_engine_alu #(.DW(DW), .GW(GW)) alu (
            .clk    (wb_clk),
            .rst    (wb_rst),
            .en     (state == S_ACC && ch_idx == CW'(i)),
            .first  (first),
            .mode   (mode_q),
            .shamt  (shamt_q),
            .sample (sample_q),
            .result (res[i]),
            .ovf    (ovf[i])
        );
    end

    // Bus outputs decoded from state; everything idles at zero.
    always_comb begin
        bus.file_num        = '0;
        bus.file_read       = 1'b0;
        bus.file_write      = 1'b0;
        bus.file_write_data = '0;
        bus.busy            = (state != S_IDLE);
        bus.done            = (state == S_DONE);
        bus.error           = err_q;
        unique case (state)
            S_READ: begin
                bus.file_num  = src_q;
                bus.file_read = 1'b1;
            end
            S_WRITE: begin
                bus.file_num        = dst_q;
                bus.file_write      = 1'b1;
                bus.file_write_data = res[ch_idx];
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_dsp_equation_engine.sv
// Directed table-driven bench for dsp_equation_engine.
// Three instances: NUM_CH = 4, 2, 1 selected by sel.
module tb_dsp_equation_engine;
    localparam int LIMIT = 2000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic [15:0] count;
    logic [7:0]  src_file;
    logic [7:0]  dst_file;
    logic        rv;
    logic [31:0] rdata;
    logic        wr_ready;
    int          sel;
    bit          stall;
    bit          hold;

    logic [7:0]  num_a [3];
    logic [31:0] wdata_a [3];
    logic [2:0]  read_a, write_a, busy_a, done_a, err_a;

    logic [7:0]  o_num;
    logic [31:0] o_wdata;
    logic        o_read, o_write, o_busy, o_done, o_err;

    int          checks = 0;
    int          errors = 0;

    logic [31:0] din [8];
    int          rd_ptr = 0;
    int          rd_base = 0;
    int          bad_num = 0;
    logic [31:0] wr_q [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dsp_equation_engine_if #(.DW(32)) bus ();
        assign bus.start            = start && (sel == g);
        assign bus.mode             = mode;
        assign bus.count            = count;
        assign bus.src_file         = src_file;
        assign bus.dst_file         = dst_file;
        assign bus.file_read_valid  = rv;
        assign bus.file_read_data   = rdata;
        assign bus.file_write_ready = wr_ready;
        assign num_a[g]   = bus.file_num;
        assign wdata_a[g] = bus.file_write_data;
        assign read_a[g]  = bus.file_read;
        assign write_a[g] = bus.file_write;
        assign busy_a[g]  = bus.busy;
        assign done_a[g]  = bus.done;
        assign err_a[g]   = bus.error;
        dsp_equation_engine #(
            .DW(32), .NUM_CH(g == 0 ? 4 : (g == 1 ? 2 : 1)), .GW(16)
        ) dut (
            .wb_clk (clk),
            .wb_rst (rst),
            .bus    (bus)
        );
    end

    always_comb begin
        o_num   = num_a[sel];
        o_wdata = wdata_a[sel];
        o_read  = read_a[sel];
        o_write = write_a[sel];
        o_busy  = busy_a[sel];
        o_done  = done_a[sel];
        o_err   = err_a[sel];
    end

    // File-store model: handshake inputs change on the falling edge.
    always @(negedge clk) begin
        if (hold)       rv = 1'b0;
        else if (stall) rv = ($urandom_range(0, 2) == 0);
        else            rv = o_read;
        wr_ready = stall ? ($urandom_range(0, 2) == 0) : o_write;
        rdata = (rd_ptr - rd_base < 8) ? din[rd_ptr - rd_base] : 32'hDEAD_BEEF;
    end

    // Record accepted reads/writes at the active edge.
    always @(posedge clk) begin
        if (o_read && rv) begin
            if (o_num != src_file) bad_num++;
            rd_ptr++;
        end
        if (o_write && wr_ready) begin
            if (o_num != dst_file) bad_num++;
            wr_q.push_back(o_wdata);
        end
    end

    typedef struct {
        int          sel;
        logic [1:0]  mode;
        int          cnt;
        int          nin;
        logic [31:0] din [8];
        int          nout;
        logic [31:0] dout [4];
        bit          err;
        int          lat;
    } vec_t;

    vec_t vt [11];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input int i, input bit st, input bit extra);
        vec_t v;
        int   lat;
        int   bad0;
        v = vt[i];
        @(negedge clk);
        sel      = v.sel;
        stall    = st;
        for (int k = 0; k < 8; k++) din[k] = v.din[k];
        rd_base  = rd_ptr;
        bad0     = bad_num;
        wr_q.delete();
        mode     = v.mode;
        count    = 16'(v.cnt);
        src_file = 8'(8'h10 + i);
        dst_file = 8'(8'h80 + i);
        start    = 1'b1;
        lat      = 1;
        @(negedge clk);
        start = 1'b0;
        lat   = 2;
        while (!o_done && lat < LIMIT) begin
            @(negedge clk);
            lat++;
            start = extra && (lat == 6);
        end
        start = 1'b0;
        chk($sformatf("v%0d done_seen", i), o_done, 1'b1);
        if (!st) chk($sformatf("v%0d latency", i), lat, v.lat);
        chk($sformatf("v%0d error", i), o_err, v.err);
        @(negedge clk);
        chk($sformatf("v%0d busy_after", i), o_busy, 1'b0);
        chk($sformatf("v%0d done_pulse", i), o_done, 1'b0);
        repeat (3) @(negedge clk);
        chk($sformatf("v%0d idle_stays", i), o_busy, 1'b0);
        chk($sformatf("v%0d reads", i), rd_ptr - rd_base, v.nin);
        chk($sformatf("v%0d writes", i), wr_q.size(), v.nout);
        chk($sformatf("v%0d file_num", i), bad_num - bad0, 0);
        for (int k = 0; k < v.nout && k < wr_q.size(); k++)
            chk($sformatf("v%0d wr%0d", i, k), wr_q[k], v.dout[k]);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " busy"}, o_busy, 1'b0);
        chk({tag, " done"}, o_done, 1'b0);
        chk({tag, " error"}, o_err, 1'b0);
        chk({tag, " file_read"}, o_read, 1'b0);
        chk({tag, " file_write"}, o_write, 1'b0);
        chk({tag, " file_num"}, o_num, 8'h00);
        chk({tag, " wdata"}, o_wdata, 32'h0);
    endtask

    initial begin
        vt[0]  = '{0, 2'd0, 2, 8, '{1, 2, 3, 4, 5, 6, 7, 8},
                   4, '{6, 8, 10, 12}, 1'b0, 22};
        vt[1]  = '{1, 2'd2, 3, 6, '{-5, 3, -1, -7, -2, 9, 0, 0},
                   2, '{-1, 9, 0, 0}, 1'b0, 16};
        vt[2]  = '{1, 2'd1, 3, 6, '{-5, 3, -1, -7, -2, 9, 0, 0},
                   2, '{-5, -7, 0, 0}, 1'b0, 16};
        vt[3]  = '{0, 2'd3, 2, 8, '{10, 20, 30, -41, -3, 4, 6, 2},
                   4, '{3, 12, 18, -20}, 1'b0, 22};
`ifdef DSP_ENGINE_SAT_EN
        vt[4]  = '{2, 2'd0, 2, 2, '{32'h7FFFFFFF, 32'h7FFFFFFF, 0, 0, 0, 0, 0, 0},
                   1, '{32'h7FFFFFFF, 0, 0, 0}, 1'b1, 7};
        vt[10] = '{2, 2'd0, 2, 2, '{32'h80000000, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0},
                   1, '{32'h80000000, 0, 0, 0}, 1'b1, 7};
`else
        vt[4]  = '{2, 2'd0, 2, 2, '{32'h7FFFFFFF, 32'h7FFFFFFF, 0, 0, 0, 0, 0, 0},
                   1, '{32'hFFFFFFFE, 0, 0, 0}, 1'b1, 7};
        vt[10] = '{2, 2'd0, 2, 2, '{32'h80000000, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0},
                   1, '{32'h7FFFFFFF, 0, 0, 0}, 1'b1, 7};
`endif
        vt[5]  = '{0, 2'd3, 3, 0, '{0, 0, 0, 0, 0, 0, 0, 0},
                   0, '{0, 0, 0, 0}, 1'b1, 2};
        vt[6]  = '{0, 2'd0, 0, 0, '{0, 0, 0, 0, 0, 0, 0, 0},
                   0, '{0, 0, 0, 0}, 1'b1, 2};
        vt[7]  = '{2, 2'd1, 4, 4, '{3, -2, 32'h80000000, 7, 0, 0, 0, 0},
                   1, '{32'h80000000, 0, 0, 0}, 1'b0, 11};
        vt[8]  = '{1, 2'd0, 2, 4, '{-100, 50, -28, -50, 0, 0, 0, 0},
                   2, '{-128, 0, 0, 0}, 1'b0, 12};
        vt[9]  = '{1, 2'd3, 4, 8, '{1, 2, 3, 4, 5, 6, 7, 9},
                   2, '{4, 5, 0, 0}, 1'b0, 20};

        rst = 1'b1; start = 1'b0; mode = '0; count = '0;
        src_file = '0; dst_file = '0; sel = 0; stall = 0; hold = 0;
        for (int k = 0; k < 8; k++) din[k] = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < 11; i++) apply(i, 1'b0, 1'b0);
        apply(0, 1'b1, 1'b1);
        apply(1, 1'b1, 1'b1);
        apply(3, 1'b1, 1'b1);

        // Reset while a read is stalled.
        @(negedge clk);
        sel = 0; stall = 0; hold = 1;
        mode = 2'd0; count = 16'd2; src_file = 8'h33; dst_file = 8'h44;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("midread file_read", o_read, 1'b1);
        chk("midread file_num", o_num, 8'h33);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_zero("midrst");
        @(negedge clk);
        rst = 1'b0; hold = 0;
        apply(0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
